// File: rtl/histeq_pkg.sv
// Shared types and constants for the histogram-equalizer phase sequencer.
package histeq_pkg;

  localparam int NUM_BINS_DEF = 256;
  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 128;
  localparam int TMO_W_DEF    = 20;

  localparam logic [1:0] OWN_CLR  = 2'd0;
  localparam logic [1:0] OWN_HIST = 2'd1;
  localparam logic [1:0] OWN_CDF  = 2'd2;
  localparam logic [1:0] OWN_MAP  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_HIST_GO,
    ST_HIST_WAIT,
    ST_CDF_GO,
    ST_CDF_WAIT,
    ST_MAP_GO,
    ST_MAP_WAIT,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic is_busy(state_e s);
    return !(s == ST_IDLE || s == ST_DONE || s == ST_ERR);
  endfunction

  function automatic logic [1:0] owner_of(state_e s);
    case (s)
      ST_HIST_GO, ST_HIST_WAIT: return OWN_HIST;
      ST_CDF_GO,  ST_CDF_WAIT:  return OWN_CDF;
      ST_MAP_GO,  ST_MAP_WAIT:  return OWN_MAP;
      default:                  return OWN_CLR;
    endcase
  endfunction

endpackage

// File: rtl/histeq_phase_ctrl_if.sv
// Handshake and m2-ownership bundle between the phase sequencer and its engines.
// HISTEQ_PERF_CNT_EN adds the cycle_count signal.
interface histeq_phase_ctrl_if
  import histeq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              start;
  logic              hist_done;
  logic              cdf_done;
  logic              map_done;
  logic              hist_start;
  logic              cdf_start;
  logic              map_start;
  logic [1:0]        m2_sel;
  logic [ADDR_W-1:0] clr_m2WriteAddr;
  logic [DATA_W-1:0] clr_m2WriteVal;
  logic              clr_m2WE;
  logic              busy;
  logic              done;
  logic              error;
`ifdef HISTEQ_PERF_CNT_EN
  logic [31:0]       cycle_count;
`endif

  modport master (
    input  start, hist_done, cdf_done, map_done,
    output hist_start, cdf_start, map_start, m2_sel,
           clr_m2WriteAddr, clr_m2WriteVal, clr_m2WE, busy, done, error
`ifdef HISTEQ_PERF_CNT_EN
    , output cycle_count
`endif
  );

  modport slave (
    output start, hist_done, cdf_done, map_done,
    input  hist_start, cdf_start, map_start, m2_sel,
           clr_m2WriteAddr, clr_m2WriteVal, clr_m2WE, busy, done, error
`ifdef HISTEQ_PERF_CNT_EN
    , input cycle_count
`endif
  );

endinterface

// File: rtl/histeq_watchdog.sv
// Per-phase watchdog: counts enabled cycles since clear; expire_o is high during the
// cycle whose increment brings the count to all-ones (i.e. the (2^TMO_W-1)th enabled cycle).
module histeq_watchdog #(
  parameter int TMO_W = 20
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TMO_W-1:0] ALL_ONES = '1;
  // Registered lookahead: flag one cycle early so it lines up with the final increment.
  localparam logic [TMO_W-1:0] PRE_EXP  = ALL_ONES - TMO_W'(2);

  logic [TMO_W-1:0] count_q;
  logic             expire_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else if (clr_i) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      if (en_i && count_q != ALL_ONES) count_q <= count_q + TMO_W'(1);
      expire_q <= en_i && (count_q == PRE_EXP);
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/histeq_phase_ctrl.sv
// Phase sequencer: CLEAR m2, then kick HIST, CDF and MAP engines in turn with watchdogs.
// HISTEQ_PERF_CNT_EN adds a saturating busy-cycle counter on cycle_count.
//
//   state     | meaning
//   IDLE      | waiting for start
//   CLEAR     | writing zero to m2[0..NUM_BINS-1], one per cycle
//   HIST_GO   | hist_start pulse, m2 owned by HIST
//   HIST_WAIT | waiting for hist_done or timeout
//   CDF_GO    | cdf_start pulse, m2 owned by CDF
//   CDF_WAIT  | waiting for cdf_done or timeout
//   MAP_GO    | map_start pulse, m2 owned by MAP
//   MAP_WAIT  | waiting for map_done or timeout
//   DONE      | frame complete, done held until next start
//   ERR       | watchdog expired, error held until next start
module histeq_phase_ctrl
  import histeq_pkg::*;
#(
  parameter int NUM_BINS = NUM_BINS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TMO_W    = TMO_W_DEF
) (
  input logic                clock,
  input logic                rst_n,
  histeq_phase_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              hist_start_q, cdf_start_q, map_start_q;
  logic [1:0]        m2_sel_q;
  logic              clr_we_q, busy_q, done_q, error_q;
  logic              start_ok, wd_clr, wd_en, wd_expire;

  assign start_ok = bus.start && !is_busy(state_q);
  assign wd_clr   = (state_q == ST_HIST_GO) || (state_q == ST_CDF_GO) || (state_q == ST_MAP_GO);
  assign wd_en    = (state_q == ST_HIST_WAIT) || (state_q == ST_CDF_WAIT) || (state_q == ST_MAP_WAIT);

  histeq_watchdog #(.TMO_W(TMO_W)) u_wdog (
    .clock    (clock),
    .rst_n    (rst_n),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // Done beats timeout: the done check comes first in every WAIT state.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_HIST_GO;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      ST_HIST_GO:   state_d = ST_HIST_WAIT;
      ST_HIST_WAIT: begin
        if (bus.hist_done)  state_d = ST_CDF_GO;
        else if (wd_expire) state_d = ST_ERR;
      end
      ST_CDF_GO:    state_d = ST_CDF_WAIT;
      ST_CDF_WAIT: begin
        if (bus.cdf_done)   state_d = ST_MAP_GO;
        else if (wd_expire) state_d = ST_ERR;
      end
      ST_MAP_GO:    state_d = ST_MAP_WAIT;
      ST_MAP_WAIT: begin
        if (bus.map_done)   state_d = ST_DONE;
        else if (wd_expire) state_d = ST_ERR;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clr_addr_q   <= '0;
      hist_start_q <= 1'b0;
      cdf_start_q  <= 1'b0;
      map_start_q  <= 1'b0;
      m2_sel_q     <= OWN_CLR;
      clr_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      hist_start_q <= (state_d == ST_HIST_GO);
      cdf_start_q  <= (state_d == ST_CDF_GO);
      map_start_q  <= (state_d == ST_MAP_GO);
      m2_sel_q     <= owner_of(state_d);
      clr_we_q     <= (state_d == ST_CLEAR);
      busy_q       <= is_busy(state_d);
      done_q       <= (state_d == ST_DONE);
      error_q      <= (state_d == ST_ERR);
    end
  end

  assign bus.hist_start      = hist_start_q;
  assign bus.cdf_start       = cdf_start_q;
  assign bus.map_start       = map_start_q;
  assign bus.m2_sel          = m2_sel_q;
  assign bus.clr_m2WriteAddr = clr_addr_q;
  assign bus.clr_m2WriteVal  = {DATA_W{1'b0}};
  assign bus.clr_m2WE        = clr_we_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.error           = error_q;

`ifdef HISTEQ_PERF_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else if (start_ok) begin
      cyc_q <= '0;
    end else if (is_busy(state_q) && cyc_q != 32'hFFFF_FFFF) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign bus.cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_histeq_phase_ctrl.sv
// Scoreboard bench for histeq_phase_ctrl: stimulus queues expected events, a negedge monitor checks them.
module tb_histeq_phase_ctrl;

  localparam int K_WR = 0, K_HS = 1, K_CS = 2, K_MS = 3, K_DONE = 4, K_ERR = 5;

  typedef struct {
    int kind;
    int v0;
    int v1;
    int v2;
    int v3;
  } ev_t;

  logic clock;
  logic rst_n;
  logic start_r, hist_done_r, cdf_done_r, map_done_r, stray_map_r;
  int   hist_lat, cdf_lat, map_lat;
  bit   cdf_hold;
  int   cyc, t0;
  int   checks, errors;
  ev_t  exp_q[$];

  histeq_phase_ctrl_if #(.ADDR_W(16), .DATA_W(128)) bus ();

  histeq_phase_ctrl #(
    .NUM_BINS (256),
    .ADDR_W   (16),
    .DATA_W   (128),
    .TMO_W    (4)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.start     = start_r;
  assign bus.hist_done = hist_done_r;
  assign bus.cdf_done  = cdf_done_r;
  assign bus.map_done  = map_done_r | stray_map_r;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int a, input int b, input int c, input int d);
    ev_t e;
    e.kind = k; e.v0 = a; e.v1 = b; e.v2 = c; e.v3 = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_t a);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual=(%0d,%0d,%0d,%0d,%0d) expected=none",
               a.kind, a.v0, a.v1, a.v2, a.v3);
    end else begin
      e = exp_q.pop_front();
      if (a != e) begin
        errors++;
        $display("FAIL event actual=(%0d,%0d,%0d,%0d,%0d) expected=(%0d,%0d,%0d,%0d,%0d)",
                 a.kind, a.v0, a.v1, a.v2, a.v3, e.kind, e.v0, e.v1, e.v2, e.v3);
      end
    end
  endtask

  // Monitor: one event per write, per start-pulse cycle, and per done/error rising edge.
  initial begin
    bit  prev_done, prev_err;
    ev_t o;
    int  perf;
    prev_done = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clock);
      perf = 0;
`ifdef HISTEQ_PERF_CNT_EN
      perf = int'(bus.cycle_count);
`endif
      if (rst_n) begin
        if (bus.clr_m2WE) begin
          o = '{K_WR, int'(bus.clr_m2WriteAddr), int'(|bus.clr_m2WriteVal), 0, 0};
          observe(o);
        end
        if (bus.hist_start) begin o = '{K_HS, int'(bus.m2_sel), 0, 0, 0}; observe(o); end
        if (bus.cdf_start)  begin o = '{K_CS, int'(bus.m2_sel), 0, 0, 0}; observe(o); end
        if (bus.map_start)  begin o = '{K_MS, int'(bus.m2_sel), 0, 0, 0}; observe(o); end
        if (bus.done && !prev_done) begin
          o = '{K_DONE, cyc - t0, int'(bus.busy), int'(bus.m2_sel), perf};
          observe(o);
        end
        if (bus.error && !prev_err) begin
          o = '{K_ERR, cyc - t0, int'(bus.busy), int'(bus.m2_sel), 0};
          observe(o);
        end
      end
      prev_done = bus.done;
      prev_err  = bus.error;
    end
  end

  // Engine models: done pulse N cycles after the start pulse.
  initial begin
    hist_done_r = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.hist_start) begin
        repeat (hist_lat) @(posedge clock);
        #1 hist_done_r = 1'b1;
        @(posedge clock);
        #1 hist_done_r = 1'b0;
      end
    end
  end

  initial begin
    cdf_done_r = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.cdf_start && !cdf_hold) begin
        repeat (cdf_lat) @(posedge clock);
        #1 cdf_done_r = 1'b1;
        @(posedge clock);
        #1 cdf_done_r = 1'b0;
      end
    end
  end

  initial begin
    map_done_r = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.map_start) begin
        repeat (map_lat) @(posedge clock);
        #1 map_done_r = 1'b1;
        @(posedge clock);
        #1 map_done_r = 1'b0;
      end
    end
  end

  task automatic push_frame(input int done_lat, input bit to_err);
    for (int i = 0; i < 256; i++) push(K_WR, i, 0, 0, 0);
    push(K_HS, 1, 0, 0, 0);
    push(K_CS, 2, 0, 0, 0);
    if (to_err) begin
      push(K_ERR, 279, 0, 0, 0);
    end else begin
      push(K_MS, 3, 0, 0, 0);
`ifdef HISTEQ_PERF_CNT_EN
      push(K_DONE, done_lat, 0, 0, done_lat - 1);
`else
      push(K_DONE, done_lat, 0, 0, 0);
`endif
    end
  endtask

  task automatic start_frame();
    @(posedge clock);
    #1 start_r = 1'b1;
    t0 = cyc;
    @(posedge clock);
    #1 start_r = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(bus.done || bus.error) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("frame_end_reached", longint'(bus.done || bus.error), 1);
  endtask

  task automatic drain();
    repeat (3) @(negedge clock);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    checks = 0; errors = 0; t0 = 0;
    rst_n = 1'b0; start_r = 1'b0; stray_map_r = 1'b0;
    hist_lat = 5; cdf_lat = 5; map_lat = 5; cdf_hold = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy",  bus.busy, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_sel",   bus.m2_sel, 0);
    chk("rst_we",    bus.clr_m2WE, 0);
    chk("rst_addr",  bus.clr_m2WriteAddr, 0);
    chk("rst_starts", {bus.hist_start, bus.cdf_start, bus.map_start}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_no_start", bus.busy, 0);

    // Nominal frame
    push_frame(275, 1'b0);
    start_frame();
    wait_end(400);
    chk("nominal_busy_in_done", bus.busy, 0);
    chk("nominal_sel_in_done", bus.m2_sel, 0);
    drain();
`ifdef HISTEQ_PERF_CNT_EN
    chk("perf_hold_in_done", bus.cycle_count, 274);
`endif

    // Restart while busy plus stray map_done in HIST_WAIT
    push_frame(275, 1'b0);
    start_frame();
    n = 0;
    while (!bus.hist_start && n < 300) begin @(negedge clock); n++; end
    chk("hist_start_seen", bus.hist_start, 1);
    @(posedge clock); #1 start_r = 1'b1;
    @(posedge clock); #1 start_r = 1'b0; stray_map_r = 1'b1;
    @(posedge clock); #1 stray_map_r = 1'b0;
    wait_end(400);
    chk("restart_done", bus.done, 1);
    drain();

    // Timeout in CDF_WAIT
    cdf_hold = 1'b1;
    push_frame(0, 1'b1);
    start_frame();
    wait_end(400);
    chk("tmo_error", bus.error, 1);
    chk("tmo_busy",  bus.busy, 0);
    chk("tmo_sel",   bus.m2_sel, 0);
    repeat (20) @(negedge clock);
    chk("tmo_error_held", bus.error, 1);
    drain();
    cdf_hold = 1'b0;
    push_frame(275, 1'b0);
    start_frame();
    @(negedge clock);
    chk("err_cleared_on_start", bus.error, 0);
    chk("busy_after_err_start", bus.busy, 1);
    chk("clear_after_err_start", bus.clr_m2WE, 1);
    wait_end(400);
    drain();

    // done coincident with watchdog expiry
    cdf_lat = 15;
    push_frame(285, 1'b0);
    start_frame();
    wait_end(400);
    chk("race_no_error", bus.error, 0);
    chk("race_done", bus.done, 1);
    drain();
    cdf_lat = 5;

    // Reset in the middle of CLEAR
    for (int i = 0; i <= 100; i++) push(K_WR, i, 0, 0, 0);
    start_frame();
    n = 0;
    while (!(bus.clr_m2WE && bus.clr_m2WriteAddr == 16'd100) && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("reached_addr_100", bus.clr_m2WriteAddr, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs_zero",
        {bus.busy, bus.done, bus.error, bus.clr_m2WE, bus.m2_sel, bus.clr_m2WriteAddr,
         bus.hist_start, bus.cdf_start, bus.map_start}, 0);
    @(posedge clock);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("midrst_stays_idle", {bus.busy, bus.clr_m2WE}, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
